// File: rtl/accum_window_stats.sv
// rtl/accum_window_stats.sv - windowed sum/min/max/count statistics over a signed sample stream
module accum_window_stats #(
  parameter int WINDOW = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] in_accum,
  input  logic        in_flush,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] out_sum,
  output logic [15:0] out_min,
  output logic [15:0] out_max,
  output logic [7:0]  out_count,
  output logic        out_overflow
);

  typedef enum logic {ST_COLLECT, ST_REPORT} state_t;

  localparam logic [7:0] C_WINDOW = 8'(WINDOW);

  state_t             r_state;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [23:0]        r_sum;
  logic signed [15:0] r_min;
  logic signed [15:0] r_max;
  logic [7:0]         r_count;
  logic               r_ovf;

  logic               w_accept;
  logic               w_first;
  logic [23:0]        w_ext;
  logic [23:0]        w_base;
  logic [24:0]        w_wide;
  logic               w_pos_sat;
  logic               w_neg_sat;
  logic [23:0]        w_sum_next;
  logic [15:0]        w_min_next;
  logic [15:0]        w_max_next;
  logic [7:0]         w_count_next;
  logic               w_ovf_next;
  logic               w_full;

  assign w_accept     = in_valid && r_in_ready;
  assign w_first      = (r_count == 8'd0);
  assign w_ext        = {{8{in_accum[15]}}, in_accum};
  // An empty window starts from zero so stale sums never leak into the next report
  assign w_base       = w_first ? 24'd0 : r_sum;
  assign w_wide       = {w_base[23], w_base} + {w_ext[23], w_ext};
  assign w_pos_sat    = (w_wide[24:23] == 2'b01);
  assign w_neg_sat    = (w_wide[24:23] == 2'b10);
  assign w_sum_next   = w_pos_sat ? 24'h7FFFFF : (w_neg_sat ? 24'h800000 : w_wide[23:0]);
  assign w_min_next   = (w_first || ($signed(in_accum) < r_min)) ? in_accum : r_min;
  assign w_max_next   = (w_first || ($signed(in_accum) > r_max)) ? in_accum : r_max;
  assign w_count_next = r_count + 8'd1;
  assign w_ovf_next   = (w_first ? 1'b0 : r_ovf) | w_pos_sat | w_neg_sat;
  assign w_full       = (w_count_next == C_WINDOW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_COLLECT;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_min       <= '0;
      r_max       <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        ST_COLLECT: begin
          if (w_accept) begin
            r_sum   <= w_sum_next;
            r_min   <= w_min_next;
            r_max   <= w_max_next;
            r_count <= w_count_next;
            r_ovf   <= w_ovf_next;
            if (w_full || in_flush) begin
              r_state     <= ST_REPORT;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end else if (in_flush && !w_first) begin
            r_state     <= ST_REPORT;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b1;
          end
        end
        ST_REPORT: begin
          if (out_ready) begin
            r_state     <= ST_COLLECT;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_count     <= '0;
          end
        end
        default: begin
          r_state     <= ST_COLLECT;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_count     <= '0;
        end
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign out_sum      = r_sum;
  assign out_min      = r_min;
  assign out_max      = r_max;
  assign out_count    = r_count;
  assign out_overflow = r_ovf;

endmodule

// File: doc/accum_window_stats.md
ACCUM_WINDOW_STATS -- requirements
Module: accum_window_stats

Interface
REQ-001 Parameter WINDOW, default 8, number of accepted samples per report; legal range 2..255.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  in_accum holds a sample this cycle.
REQ-005 in_accum  input  16  accumulator result sample, two's-complement signed.
REQ-006 in_flush  input  1  close the current window early and report it.
REQ-007 in_ready  output  1  block accepts a sample this cycle.
REQ-008 out_valid  output  1  report fields valid.
REQ-009 out_ready  input  1  consumer takes the report this cycle.
REQ-010 out_sum  output  24  signed saturating sum of window samples.
REQ-011 out_min  output  16  signed minimum of window samples.
REQ-012 out_max  output  16  signed maximum of window samples.
REQ-013 out_count  output  8  number of samples in the reported window.
REQ-014 out_overflow  output  1  sum saturated at least once in the window.

Function
REQ-015 Two states, COLLECT and REPORT; reset enters COLLECT.
REQ-016 COLLECT: in_ready=1, out_valid=0; REPORT: in_ready=0, out_valid=1.
REQ-017 Sample accepted only when in_valid and in_ready are both 1 on a rising edge.
REQ-018 First accepted sample of a window loads sum=sign-extended sample, min=max=sample, count=1, overflow=0.
REQ-019 Later samples: sum=sum+sign-extended sample, min/max updated by signed compare, count+1.
REQ-020 Sum saturates at +8388607 / -8388608; any saturating add sets overflow, sticky until window clears.
REQ-021 Acceptance that makes count equal WINDOW moves to REPORT on that edge; out_valid high the next cycle.
REQ-022 in_flush in COLLECT with count>0 moves to REPORT on that edge with the partial count.
REQ-023 in_flush with in_valid accepted on the same edge: sample is included, then REPORT.
REQ-024 in_flush in COLLECT with count=0 and no accepted sample is ignored; in_flush in REPORT is ignored.
REQ-025 All out_* fields registered and held stable while out_valid=1 and out_ready=0.
REQ-026 out_valid and out_ready both 1 on an edge: return to COLLECT, count cleared; in_ready=1 next cycle.
REQ-027 No sample accepted in the handshake-completion cycle (in_ready=0 there).
REQ-028 out_sum/out_min/out_max/out_count/out_overflow reflect internal registers at all times; only meaningful when out_valid=1.
REQ-029 Throughput: WINDOW samples on consecutive cycles with no stall; one bubble cycle minimum per report.

Reset
REQ-030 rst_n low asynchronously forces COLLECT, in_ready=1 after release, out_valid=0, out_sum=0, out_min=0, out_max=0, out_count=0, out_overflow=0.
REQ-031 Reset mid-window or mid-report discards all partial state; no report emitted for the aborted window.
REQ-032 First edge after rst_n deasserts may accept a sample.

Verification
REQ-033 WINDOW=8, samples 1..8 back-to-back, out_ready=1 -> one cycle after 8th: out_valid=1, sum=36, min=1, max=8, count=8, overflow=0.
REQ-034 Samples 0x7FFF x8 (WINDOW=8) -> sum=262136, overflow=0; samples -5, 3, -32768, 100 then flush -> sum=-32670, min=-32768, max=100, count=4.
REQ-035 WINDOW=255, 255 samples of 0x7FFF -> sum=8355585, no overflow; repeat with WINDOW=255 and a forced sum preload path via 256+ samples across flush-free windows shows per-window clearing (overflow=0 each).
REQ-036 Report held with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, fields stable, no samples lost or taken; out_ready=1 -> COLLECT next cycle.
REQ-037 Flush with count=0 -> no report; flush with sample 9 on same edge after samples 2,4 -> count=3, sum=15, min=2, max=9.
REQ-038 rst_n pulsed low asynchronously mid-window after 3 samples -> outputs zero immediately; next 8 samples 10 each -> sum=80, count=8.
